// File: rtl/difftest_stream_pkg.sv
// Shared types and sizing helpers for the difftest batch streamer.
// Beat count and index-width math live here so the FIFO and top agree.
package difftest_stream_pkg;

    function automatic int beats(input int batch_w, input int stream_w);
        return (batch_w + stream_w - 1) / stream_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        IDLE,
        SEND
    } serializer_state_e;

endpackage

// File: rtl/difftest_sync_fifo.sv
// First-word-fall-through synchronous FIFO for whole batch words.
// Fullness is judged on the registered count only.
module difftest_sync_fifo
    import difftest_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      pop,
    output logic [WIDTH-1:0]          rdata,
    output logic [idx_width(DEPTH):0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = idx_width(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/difftest_batch_streamer.sv
// Buffers wide difftest batch words and serializes them into AXI-Stream beats,
// with core backpressure and sticky overflow / saturating drop counting.
module difftest_batch_streamer
    import difftest_stream_pkg::*;
#(
    parameter int BATCH_WIDTH  = 4096,
    parameter int STREAM_WIDTH = 512,
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rstn_i,
    input  logic [BATCH_WIDTH-1:0]  in_data,
    input  logic                    in_enable,
    output logic                    core_stall,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    input  logic                    clear_i,
    output logic                    overflow_o,
    output logic [CNT_WIDTH-1:0]    drop_count_o
);

    localparam int BEATS = beats(BATCH_WIDTH, STREAM_WIDTH);
    localparam int IW    = idx_width(BEATS);
    localparam int AW    = idx_width(DEPTH);
    localparam int PW    = BEATS * STREAM_WIDTH;

    localparam logic [IW-1:0]        LAST_BEAT = IW'(BEATS - 1);
    localparam logic [AW:0]          STALL_AT  = (AW + 1)'(DEPTH - STALL_MARGIN);
    localparam logic [AW:0]          ONE_LEFT  = (AW + 1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    serializer_state_e state, next_state;

    logic [IW-1:0]          beat_idx, beat_next;
    logic [AW:0]            count;
    logic                   full, empty;
    logic                   push_ok, drop, pop, is_last;
    logic [BATCH_WIDTH-1:0] head;
    logic [PW-1:0]          flat;
    logic [BEATS-1:0][STREAM_WIDTH-1:0] slices;

    difftest_sync_fifo #(
        .WIDTH (BATCH_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst_n (sys_rstn_i),
        .push  (in_enable),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign push_ok = in_enable && !full;
    assign drop    = in_enable && full;
    assign is_last = (beat_idx == LAST_BEAT);

    // Zero-pad the head word so the final beat carries 0 above BATCH_WIDTH.
    always_comb begin
        flat = '0;
        flat[BATCH_WIDTH-1:0] = head;
    end

    assign slices        = flat;
    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tlast  = (state == SEND) && is_last;
    assign m_axis_tdata  = (state == SEND) ? slices[beat_idx] : '0;
    assign core_stall    = (count >= STALL_AT);

    always_comb begin
        next_state = state;
        beat_next  = beat_idx;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty || push_ok) next_state = SEND;
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (is_last) begin
                        pop       = 1'b1;
                        beat_next = '0;
                        if (count == ONE_LEFT && !push_ok) next_state = IDLE;
                    end else begin
                        beat_next = beat_idx + 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state    <= IDLE;
            beat_idx <= '0;
        end else begin
            state    <= next_state;
            beat_idx <= beat_next;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (clear_i) begin
            overflow_o   <= drop;
            drop_count_o <= CNT_WIDTH'(drop);
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != CNT_MAX) drop_count_o <= drop_count_o + 1'b1;
        end
    end

endmodule
